// File: rtl/rr_arbiter_4_pkg.sv
//------------------------------------------------------------------------------
// Module  : rr_arbiter_4_pkg
// Brief   : Shared types, sizes and the 4-to-2 encoder for the 4-way arbiter.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package rr_arbiter_4_pkg;

  localparam int REQ_N = 4;
  localparam int IDXW  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Lowest set bit wins, so a one-hot input yields its plain binary index.
  function automatic logic [IDXW-1:0] enc4to2(input logic [REQ_N-1:0] v);
    logic [IDXW-1:0] r;
    r = '0;
    for (int i = REQ_N - 1; i >= 0; i--) begin
      if (v[i]) r = IDXW'(i);
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick_4.sv
//------------------------------------------------------------------------------
// Module  : rr_pick_4
// Brief   : Combinational rotating priority pick: search from i_start upward.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick_4
  import rr_arbiter_4_pkg::*;
(
  input  logic [REQ_N-1:0] i_req,
  input  logic [IDXW-1:0]  i_start,
  output logic             o_hit,
  output logic [IDXW-1:0]  o_idx,
  output logic [REQ_N-1:0] o_onehot
);

  logic [2*REQ_N-1:0] w_dbl;
  logic [REQ_N-1:0]   w_rot;
  logic [IDXW-1:0]    w_off;

  // Doubling the vector turns the rotate into a plain part-select.
  assign w_dbl    = {i_req, i_req};
  assign w_rot    = w_dbl[i_start +: REQ_N];
  assign w_off    = enc4to2(w_rot);
  assign o_hit    = |i_req;
  assign o_idx    = i_start + w_off;
  assign o_onehot = o_hit ? (REQ_N'(1) << o_idx) : '0;

endmodule

`default_nettype wire

// File: rtl/rr_arbiter_4.sv
//------------------------------------------------------------------------------
// Module  : rr_arbiter_4
// Brief   : Hold-limited round-robin arbiter for four requesters, registered out.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNTW     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ_N-1:0] req,
  output logic [REQ_N-1:0] grant,
  output logic [IDXW-1:0]  grant_idx,
  output logic             grant_valid
);

  localparam logic [CNTW-1:0] c_max_hold = CNTW'(MAX_HOLD);

  state_t            r_state, w_state;
  logic [IDXW-1:0]   r_last,  w_last;
  logic [CNTW-1:0]   r_hold,  w_hold;
  logic [REQ_N-1:0]  r_grant, w_grant;
  logic [IDXW-1:0]   r_idx,   w_idx;
  logic              r_valid, w_valid;

  logic              w_hit;
  logic [IDXW-1:0]   w_pick_idx;
  logic [REQ_N-1:0]  w_pick_onehot;
  logic              w_keep;

  // Search starts just past the last owner, so the owner is considered last.
  rr_pick_4 u_pick (
    .i_req    (req),
    .i_start  (r_last + IDXW'(1)),
    .o_hit    (w_hit),
    .o_idx    (w_pick_idx),
    .o_onehot (w_pick_onehot)
  );

  assign w_keep = (r_state == BUSY) && req[r_last] && (r_hold < c_max_hold);

  always_comb begin
    w_state = r_state;
    w_last  = r_last;
    w_hold  = r_hold;
    w_grant = r_grant;
    w_idx   = r_idx;
    w_valid = r_valid;
    if (w_keep) begin
      w_hold = r_hold + CNTW'(1);
    end else if (w_hit) begin
      w_state = BUSY;
      w_last  = w_pick_idx;
      w_hold  = CNTW'(1);
      w_grant = w_pick_onehot;
      w_idx   = w_pick_idx;
      w_valid = 1'b1;
    end else begin
      w_state = IDLE;
      w_hold  = '0;
      w_grant = '0;
      w_idx   = '0;
      w_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= IDXW'(REQ_N - 1);
      r_hold  <= '0;
      r_grant <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state;
      r_last  <= w_last;
      r_hold  <= w_hold;
      r_grant <= w_grant;
      r_idx   <= w_idx;
      r_valid <= w_valid;
    end
  end

  assign grant       = r_grant;
  assign grant_idx   = r_idx;
  assign grant_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_4.sv
//------------------------------------------------------------------------------
// Module  : tb_rr_arbiter_4
// Brief   : Directed bench for rr_arbiter_4 with a reference model scoreboard.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rr_arbiter_4;

  localparam int MAX_HOLD = 4;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] i;
    logic       v;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;

  int checks = 0;
  int errors = 0;

  exp_t       sb[$];
  logic [3:0] obs_grant;

  // reference model state
  bit         m_busy;
  int         m_last;
  int         m_hold;
  logic [3:0] m_grant;
  logic [1:0] m_idx;

  rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CNTW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_last  = 3;
    m_hold  = 0;
    m_grant = 4'b0000;
    m_idx   = 2'd0;
  endtask

  task automatic model_step(input logic [3:0] r);
    int  w;
    bit  found;
    if (m_busy && r[m_last] && m_hold < MAX_HOLD) begin
      m_hold++;
    end else begin
      found = 1'b0;
      w     = 0;
      for (int k = 1; k <= 4; k++) begin
        if (!found && r[(m_last + k) % 4]) begin
          found = 1'b1;
          w     = (m_last + k) % 4;
        end
      end
      if (found) begin
        m_busy  = 1'b1;
        m_last  = w;
        m_hold  = 1;
        m_grant = 4'b0001 << w;
        m_idx   = 2'(w);
      end else begin
        m_busy  = 1'b0;
        m_hold  = 0;
        m_grant = 4'b0000;
        m_idx   = 2'd0;
      end
    end
  endtask

  function automatic logic [1:0] enc(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // One clock: drive req on the falling edge, check just after the rising edge.
  task automatic step(input logic [3:0] r);
    exp_t e;
    @(negedge clk);
    req = r;
    model_step(r);
    sb.push_back('{g: m_grant, i: m_idx, v: m_busy});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("grant", 32'(grant), 32'(e.g));
    chk("grant_idx", 32'(grant_idx), 32'(e.i));
    chk("grant_valid", 32'(grant_valid), 32'(e.v));
    chk("onehot0", 32'($onehot0(grant)), 32'd1);
    chk("idx_enc", 32'(grant_idx), 32'(enc(grant)));
    obs_grant = grant;
  endtask

  // Asserts reset between clock edges and checks that outputs clear at once.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    req = 4'b0000;
    model_reset();
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_idx", 32'(grant_idx), 32'd0);
    chk("rst_valid", 32'(grant_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    model_reset();
    #2;
    chk("init_grant", 32'(grant), 32'd0);
    chk("init_valid", 32'(grant_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: idle
    for (int i = 0; i < 5; i++) begin
      step(4'b0000);
      chk("t1_grant", 32'(obs_grant), 32'd0);
    end

    // 2: two requesters alternate every MAX_HOLD cycles
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(4'b0101);
      chk("t2_grant", 32'(obs_grant), (i >= 4 && i < 8) ? 32'h4 : 32'h1);
    end

    // 3: short pulse, return to idle, pointer then favours requester 0
    do_reset();
    step(4'b1000);
    chk("t3_g0", 32'(obs_grant), 32'h8);
    step(4'b1000);
    chk("t3_g1", 32'(obs_grant), 32'h8);
    step(4'b0000);
    chk("t3_idle", 32'(obs_grant), 32'h0);
    step(4'b1001);
    chk("t3_wrap", 32'(obs_grant), 32'h1);

    // 4: full contention rotates through all four
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(4'b1111);
      chk("t4_grant", 32'(obs_grant), 32'h1 << (i / 4));
    end

    // 5: lone requester is regranted across hold expiry
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(4'b0010);
      chk("t5_grant", 32'(obs_grant), 32'h2);
    end
    step(4'b0000);
    chk("t5_release", 32'(obs_grant), 32'h0);

    // 6: asynchronous reset in the middle of a grant
    do_reset();
    step(4'b0100);
    step(4'b0100);
    chk("t6_pre", 32'(obs_grant), 32'h4);
    do_reset();
    step(4'b0100);
    chk("t6_post", 32'(obs_grant), 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
